// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// window of GATE_CYCLES clk cycles and reports the result with a valid pulse.
// Optional build macro FREQ_METER_SAT_EN: the edge counter saturates at
// all-ones and ovf flags any edge lost to saturation. Without it the counter
// wraps and ovf is tied low.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf
);

  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               prev_q;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic               edge_det;
  logic [CNT_W-1:0]   edge_next;
  logic               ovf_next;

  // Synchronizer and previous-value register run in every state, so in IDLE
  // prev_q already tracks the input and a high level is never seen as an edge.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would collapse the 2-flop synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig_in};
      prev_q <= sync_q[1];
    end
  end

  assign edge_det = sync_q[1] & ~prev_q;

  // Edge counter step for the current cycle, including an edge on the last
  // gate cycle, so the final result can be loaded straight from it.
  always_comb begin
    edge_next = edge_cnt_q;
    ovf_next  = ovf_acc_q;
    if (edge_det) begin
`ifdef FREQ_METER_SAT_EN
      if (edge_cnt_q == '1) begin
        ovf_next = 1'b1;
      end else begin
        edge_next = edge_cnt_q + 1'b1;
      end
`else
      edge_next = edge_cnt_q + 1'b1;
      ovf_next  = 1'b0;
`endif
    end
  end

  // Next-state and result logic for the IDLE/MEASURE controller.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = MEASURE;
          gate_d     = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end
      end
      MEASURE: begin
        edge_cnt_d = edge_next;
        ovf_acc_d  = ovf_next;
        gate_d     = gate_q + 1'b1;
        if (gate_q == GATE_LAST) begin
          state_d = IDLE;
          count_d = edge_next;
          ovf_d   = ovf_next;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state, counters and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      ovf_acc_q  <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign busy  = (state_q == MEASURE);
  assign count = count_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives two freq_meter instances (CNT_W=8 and CNT_W=4, both
// with a 100-cycle gate) from one stimulus stream. The expected edge count is
// taken from a history of the sampled input: the 2-flop synchronizer means a
// window started at clock edge N0 sees rising transitions at samples
// N0-1 .. N0+98. Wrap/saturate rules are applied with plain arithmetic.
module tb_freq_meter;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sig_in = 1'b0;
  logic       busy8, valid8, ovf8;
  logic [7:0] count8;
  logic       busy4, valid4, ovf4;
  logic [3:0] count4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit hist [65536];
  int per = 10;
  int hi  = 5;
  int base = 0;
  bit force_hi = 1'b0;
  int prev8 = 0;
  int prev4 = 0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
    .busy(busy8), .count(count8), .valid(valid8), .ovf(ovf8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
    .busy(busy4), .count(count4), .valid(valid4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  // Record the value sampled at each edge, then drive the next sample.
  // Sample e has value ((e - base) mod per) < hi.
  always @(posedge clk) begin
    hist[cyc % 65536] = sig_in;
    cyc = cyc + 1;
    #2;
    sig_in = force_hi ? 1'b1 : ((((cyc - base) % per) + per) % per < hi);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rises(input int lo, input int hi_i);
    int n = 0;
    for (int m = lo; m <= hi_i; m++)
      if (hist[m % 65536] && !hist[(m - 1) % 65536]) n++;
    return n;
  endfunction

  function automatic int exp_cnt(input int e, input int w);
    int mx = (1 << w) - 1;
`ifdef FREQ_METER_SAT_EN
    return (e > mx) ? mx : e;
`else
    return e % (mx + 1);
`endif
  endfunction

  function automatic int exp_ovf(input int e, input int w);
`ifdef FREQ_METER_SAT_EN
    return (e > ((1 << w) - 1)) ? 1 : 0;
`else
    return (e < 0 || w < 0) ? 1 : 0;
`endif
  endfunction

  // Runs one window starting at the current negedge. hold keeps start high at
  // the end (back-to-back), repulse re-asserts start at cycles 30 and 60,
  // abort_at>0 pulses rst at that cycle, sw switches to period 5 so that the
  // following window begins with a fresh rise.
  task automatic run_window(input bit hold, input bit repulse, input int abort_at, input bit sw);
    int n0, r, nvalid, nbusy, vr, e;
    start  = 1'b1;
    n0     = cyc;
    nvalid = 0;
    nbusy  = 0;
    vr     = -1;
    for (int i = 1; i <= G + 1; i++) begin
      @(negedge clk);
      r = cyc - n0;
      if (!hold) start = repulse && (r == 30 || r == 60);
      if (abort_at == r) begin
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_valid", valid8, 0);
        check("abort_count8", count8, 0);
        check("abort_ovf8", ovf8, 0);
        check("abort_count4", count4, 0);
        check("abort_ovf4", ovf4, 0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        prev8 = 0;
        prev4 = 0;
        repeat (5) begin
          @(negedge clk);
          if (valid8 || valid4 || busy8) nvalid++;
        end
        check("abort_quiet", nvalid, 0);
        return;
      end
      if (sw && r == 99) begin
        per  = 5;
        hi   = 2;
        base = cyc + 1;
      end
      if (busy8) nbusy++;
      if (valid8) begin
        nvalid++;
        if (vr < 0) vr = r;
      end
      if (r == 50) begin
        check("hold_count8", count8, prev8);
        check("hold_count4", count4, prev4);
      end
    end
    e = rises(n0 - 1, n0 + G - 2);
    check("valid_latency", vr, G + 1);
    check("valid_once", nvalid, 1);
    check("busy_cycles", nbusy, G);
    check("valid4_sync", valid4, 1);
    check("count8", count8, exp_cnt(e, 8));
    check("ovf8", ovf8, exp_ovf(e, 8));
    check("count4", count4, exp_cnt(e, 4));
    check("ovf4", ovf4, exp_ovf(e, 4));
    prev8 = exp_cnt(e, 8);
    prev4 = exp_cnt(e, 4);
    if (!hold) begin
      @(negedge clk);
      check("valid_width", valid8, 0);
      check("idle_busy", busy8, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_valid", valid8, 0);
    check("rst_count", count8, 0);
    check("rst_ovf", ovf8, 0);
    check("rst_count4", count4, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Period 10, random phase and duty.
    per  = 10;
    hi   = $urandom_range(2, 8);
    base = cyc + $urandom_range(0, 9);
    repeat (12) @(negedge clk);
    run_window(1'b0, 1'b0, 0, 1'b0);
    check("p10_count", count8, 10);
    check("p10_count4", count4, 10);
    check("p10_ovf", ovf8, 0);

    // Input already high before and through the window.
    force_hi = 1'b1;
    repeat (5) @(negedge clk);
    run_window(1'b0, 1'b0, 0, 1'b0);
    check("high_count", count8, 0);
    force_hi = 1'b0;

    // Period 4 overflows the 4-bit counter (25 edges).
    per  = 4;
    hi   = 2;
    base = cyc;
    repeat (8) @(negedge clk);
    run_window(1'b0, 1'b0, 0, 1'b0);
    check("p4_count8", count8, 25);
`ifdef FREQ_METER_SAT_EN
    check("p4_count4", count4, 15);
    check("p4_ovf4", ovf4, 1);
`else
    check("p4_count4", count4, 9);
    check("p4_ovf4", ovf4, 0);
`endif

    // start re-pulsed mid-window is ignored.
    per  = 10;
    hi   = 5;
    base = cyc;
    repeat (12) @(negedge clk);
    run_window(1'b0, 1'b1, 0, 1'b0);
    check("repulse_count", count8, 10);

    // Held start: period 20 then period 5, back-to-back windows.
    per  = 20;
    hi   = 10;
    base = cyc;
    repeat (40) @(negedge clk);
    run_window(1'b1, 1'b0, 0, 1'b1);
    check("p20_count", count8, 5);
    run_window(1'b0, 1'b0, 0, 1'b0);
    check("p5_count", count8, 20);

    // Reset mid-window, then a complete fresh window.
    per  = 10;
    hi   = 5;
    base = cyc + $urandom_range(0, 9);
    repeat (12) @(negedge clk);
    run_window(1'b0, 1'b0, 50, 1'b0);
    repeat (3) @(negedge clk);
    run_window(1'b0, 1'b0, 0, 1'b0);
    check("after_rst_count", count8, 10);

    // Randomized waveforms and start modes.
    for (int k = 0; k < 8; k++) begin
      per  = $urandom_range(4, 30);
      hi   = $urandom_range(2, per - 2);
      base = cyc + $urandom_range(0, per - 1);
      run_window(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, gate window length in clk cycles (1 s at 100 MHz); legal range 2 or more.
REQ-002 Parameter CNT_W, default 27, width of the edge counter and of the count output.
REQ-003 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, reset: asynchronous, active-high.
REQ-005 Port start, input, 1, measurement request, sampled only in IDLE.
REQ-006 Port sig_in, input, 1, asynchronous signal to measure, e.g. a divided clock from the divider chain.
REQ-007 Port busy, output, 1, high while a measurement is in progress.
REQ-008 Port count, output, CNT_W, rising-edge count from the last completed gate window.
REQ-009 Port valid, output, 1, one-cycle pulse when count updates.
REQ-010 Port ovf, output, 1, set when the edge count exceeded 2^CNT_W-1 in the last window.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer that runs in every state.
REQ-012 An edge SHALL be a synchronized high with previous synchronized low; in IDLE the previous-value register tracks the synchronized signal so an already-high input is never counted at start.
REQ-013 The FSM SHALL have states IDLE and MEASURE: IDLE->MEASURE when start=1 at cycle 0; busy=1 from cycle 1.
REQ-014 MEASURE SHALL last exactly GATE_CYCLES clk cycles (cycles 1..GATE_CYCLES), counting every detected edge, including an edge on the last gate cycle.
REQ-015 At cycle GATE_CYCLES+1 the block SHALL load count and ovf, pulse valid for one cycle, drop busy, and return to IDLE.
REQ-016 start sampled high in the valid cycle SHALL begin a new measurement, so a held start gives back-to-back windows with no idle gap.
REQ-017 start asserted during MEASURE SHALL be ignored with no queuing.
REQ-018 count and ovf SHALL hold the last result until the next valid.
REQ-019 The edge and gate counters SHALL clear on entry to MEASURE.
REQ-020 Results are exact for sig_in periods of at least 4 clk cycles with high and low phases of at least 2 cycles each; behaviour is unspecified for faster inputs.

Reset
REQ-021 rst SHALL immediately force IDLE, busy=0, valid=0, count=0, ovf=0, and clear the synchronizer, edge register and counters.
REQ-022 rst during MEASURE SHALL abort the window with no valid pulse; the first start after rst deassertion gives a complete fresh window.

Configuration
REQ-023 Macro FREQ_METER_SAT_EN: when defined, the edge counter SHALL saturate at 2^CNT_W-1 and any further edge SHALL set ovf for that window.
REQ-024 Without FREQ_METER_SAT_EN, the counter SHALL wrap modulo 2^CNT_W and ovf SHALL be constant 0.

Verification (GATE_CYCLES=100, CNT_W=8 unless noted)
REQ-025 sig_in period 10 clk, any phase, start pulse -> valid exactly 101 cycles after start sample, count=10, ovf=0, busy high for 100 cycles.
REQ-026 sig_in held high before and through the window -> count=0, valid pulses once.
REQ-027 CNT_W=4, sig_in period 4 -> with FREQ_METER_SAT_EN count=15, ovf=1; without it count=9 (25 mod 16), ovf=0.
REQ-028 start re-pulsed at cycles 30 and 60 of a window -> one valid only, count unaffected; start held high -> second valid 101 cycles after the first.
REQ-029 rst pulsed at cycle 50 of a window -> outputs 0 immediately, no valid; the next start with period 10 -> count=10.
REQ-030 sig_in period 20 for one window, then period 5 for the next (start held) -> count=5, then count=20; count stable between valids.
